mips_multi_cycle_cpu: RTL and testbench
=======================================

// Module: mips_multi_cycle_cpu
// PURPOSE
//   32-bit MIPS-I subset CPU, multi-cycle, non-pipelined: one ALU, one unified instr/data memory.
//   Each instruction passes through FSM states, one state per clock.
//   Top-level core; exposes register file, PC and current instruction for debug/verification.
//   Program image loads by hierarchical $readmemh into <dut>.i_ram.mem.
// PARAMETERS
//   MEM_DEPTH  256  unified memory size in 32-bit words. Instance name i_ram, array mem[0:MEM_DEPTH-1].
// PORTS
//   clk          in   1        single clock, rising edge
//   reset        in   1        asynchronous, active-low reset
//   regs_debug   out  32x32    unpacked [0:31] of [31:0], live register file contents
//   pc_debug     out  32       current PC register
//   instr_debug  out  32       instruction register (IR) contents
// BEHAVIOUR
//   Reset (async assert): PC=0, IR=0, FSM=FETCH, all regs=0. Memory contents preserved.
//   Memory addressing:
//     - word index = byte_addr[2+:log2(MEM_DEPTH)], upper bits ignored (wraps)
//     - combinational read; write on posedge clk only in MEMWRITE
//   Register file:
//     - $0 reads 0, writes ignored
//     - written on posedge in write-back states only
//   Supported instructions:
//     - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr
//     - I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne
//     - J-type: j, jal ($31 = PC+4)
//   Arithmetic/width rules:
//     - add/addi do not trap on overflow; 32-bit wraparound result
//     - addi/addiu/slti/sltiu sign-extend imm16; andi/ori/xori zero-extend
//     - slt is signed compare; sltu/sltiu unsigned
//     - shamt from instr[10:6]; variable shifts use rs[4:0]; sra arithmetic
//   FSM, one clock per state:
//     - FETCH: IR<=mem[PC]; PC<=PC+4 -> DECODE
//     - DECODE: latch A=rs, B=rt, sign-extended imm -> per-opcode state
//     - R_EXEC -> R_WB (rd<=ALUOut) -> FETCH: 4 cycles
//     - I_EXEC -> I_WB (rt<=ALUOut) -> FETCH: 4 cycles
//     - MEMADR -> MEMREAD -> MEMWB (rt<=MDR) -> FETCH: lw 5 cycles
//     - MEMADR -> MEMWRITE -> FETCH: sw 4 cycles
//     - BRANCH: taken -> PC <= PC+4 + (simm<<2) -> FETCH: 3 cycles
//     - JUMP: PC <= {PC+4[31:28], target, 2'b00}; jr: PC <= rs -> FETCH: 3 cycles
//   Unknown opcode/funct: executes as NOP (DECODE -> FETCH), no state change besides PC+4.
//   No delay slots. Reset mid-instruction aborts it; a partially done sw never writes after reset.
//   Worst-case CPI 5, so N instructions finish within 5N cycles after reset release.
// TESTING
//   1. Arith: addiu $t0,$0,10; addiu $t1,$0,20; add/addu $s4/$s5 -> 0x1E; sub/subu $s6/$s7 -> 0xFFFFFFF6.
//   2. Immediates: addiu $a1,$0,-1 -> 0xFFFFFFFF; addi $t3,$t1,-4 -> 0x10; addi $t4,$t0,-20 -> 0xFFFFFFF6.
//   3. Compare: slt 10<0 -> 0; sltu 10<0 -> 0; slt 10<20 -> 1; sltu 3<0xFFFFFFFF -> 1.
//   4. Shifts: sll 10<<3 -> 0x50; srl 3>>1 -> 1; sra 3>>>1 -> 1;
//      sra 0x80000000 by 4 -> 0xF8000000; sllv 10<<$s0(=3) -> 0x50.
//   5. Memory/control: sw 0x1234 to 0x40 then lw -> 0x1234; beq taken skips next instr;
//      j loops; write to $0 keeps it 0.
//   6. Async reset: assert reset low mid-lw -> PC=0, regs=0 immediately without clock;
//      program reruns correctly after release.

Source files
------------

// File: rtl/mips_multi_cycle_cpu.sv
// Multi-cycle MIPS-I subset core with a unified word-addressed instruction/data memory.
// Each instruction walks FETCH -> DECODE -> class-specific states, one state per clock.

module mips_unified_ram #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0]   mem [0:MEM_DEPTH-1];
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    // Byte address selects a word; bits above the array size wrap.
    assign idx              = addr[2 +: AW];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign rdata            = mem[idx];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end
endmodule

module mips_multi_cycle_cpu #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] regs_debug [0:31],
    output logic [31:0] pc_debug,
    output logic [31:0] instr_debug
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
        S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_LW = 6'h23, OP_SW = 6'h2B;

    state_t      state, decode_next;
    logic [31:0] pc, ir, a, b, imm, alu_out, mdr;
    logic [31:0] regs [0:31];
    logic [31:0] mem_rdata, mem_addr, simm, zimm, r_result, i_result;
    logic        mem_we, branch_taken;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd, shamt;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign simm  = {{16{ir[15]}}, ir[15:0]};
    assign zimm  = {16'h0000, ir[15:0]};

    assign mem_addr = (state == S_FETCH) ? pc : alu_out;
    assign mem_we   = (state == S_MEMWRITE);

    mips_unified_ram #(.MEM_DEPTH(MEM_DEPTH)) i_ram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (b),
        .rdata (mem_rdata)
    );

    assign regs_debug  = regs;
    assign pc_debug    = pc;
    assign instr_debug = ir;

    // Unsupported opcodes and functs fall back to FETCH, so they retire as NOPs.
    always_comb begin
        decode_next = S_FETCH;
        case (op)
            OP_R: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: decode_next = S_R_EXEC;
                    6'h08:                      decode_next = S_JUMP;
                    default:                    decode_next = S_FETCH;
                endcase
            end
            OP_J, OP_JAL:                         decode_next = S_JUMP;
            OP_BEQ, OP_BNE:                       decode_next = S_BRANCH;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:           decode_next = S_I_EXEC;
            OP_LW, OP_SW:                         decode_next = S_MEMADR;
            default:                              decode_next = S_FETCH;
        endcase
    end

    always_comb begin
        r_result = '0;
        case (funct)
            6'h00:        r_result = b << shamt;
            6'h02:        r_result = b >> shamt;
            6'h03:        r_result = $signed(b) >>> shamt;
            6'h04:        r_result = b << a[4:0];
            6'h06:        r_result = b >> a[4:0];
            6'h07:        r_result = $signed(b) >>> a[4:0];
            6'h20, 6'h21: r_result = a + b;
            6'h22, 6'h23: r_result = a - b;
            6'h24:        r_result = a & b;
            6'h25:        r_result = a | b;
            6'h26:        r_result = a ^ b;
            6'h27:        r_result = ~(a | b);
            6'h2A:        r_result = {31'b0, $signed(a) < $signed(b)};
            6'h2B:        r_result = {31'b0, a < b};
            default:      r_result = '0;
        endcase
    end

    always_comb begin
        i_result = '0;
        case (op)
            6'h08, 6'h09: i_result = a + imm;
            6'h0A:        i_result = {31'b0, $signed(a) < $signed(imm)};
            6'h0B:        i_result = {31'b0, a < imm};
            6'h0C:        i_result = a & zimm;
            6'h0D:        i_result = a | zimm;
            6'h0E:        i_result = a ^ zimm;
            6'h0F:        i_result = {ir[15:0], 16'h0000};
            default:      i_result = '0;
        endcase
    end

    assign branch_taken = (op == OP_BEQ) ? (a == b) : (a != b);

    // PC already holds PC+4 after FETCH; branch, jump and jal link are relative to it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 32'd4;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a     <= regs[rs];
                    b     <= regs[rt];
                    imm   <= simm;
                    state <= decode_next;
                end
                S_R_EXEC: begin
                    alu_out <= r_result;
                    state   <= S_R_WB;
                end
                S_R_WB: begin
                    if (rd != 5'd0) regs[rd] <= alu_out;
                    state <= S_FETCH;
                end
                S_I_EXEC: begin
                    alu_out <= i_result;
                    state   <= S_I_WB;
                end
                S_I_WB: begin
                    if (rt != 5'd0) regs[rt] <= alu_out;
                    state <= S_FETCH;
                end
                S_MEMADR: begin
                    alu_out <= a + imm;
                    state   <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mdr   <= mem_rdata;
                    state <= S_MEMWB;
                end
                S_MEMWB: begin
                    if (rt != 5'd0) regs[rt] <= mdr;
                    state <= S_FETCH;
                end
                S_MEMWRITE: state <= S_FETCH;
                S_BRANCH: begin
                    if (branch_taken) pc <= pc + {imm[29:0], 2'b00};
                    state <= S_FETCH;
                end
                S_JUMP: begin
                    if (op == OP_R) begin
                        pc <= a;
                    end else begin
                        pc <= {pc[31:28], ir[25:0], 2'b00};
                        if (op == OP_JAL) regs[31] <= pc;
                    end
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multi_cycle_cpu.sv
// Bench for mips_multi_cycle_cpu: an instruction-level interpreter predicts architectural
// state and cycle cost of every instruction; directed and random programs are compared.

module tb_mips_multi_cycle_cpu;
    logic        clk;
    logic        reset;
    logic [31:0] regs_debug [0:31];
    logic [31:0] pc_debug;
    logic [31:0] instr_debug;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog     [0:255];
    logic [31:0] mdl_mem  [0:255];
    logic [31:0] mdl_regs [0:31];
    logic [31:0] mdl_pc;
    logic [31:0] mdl_ir;

    mips_multi_cycle_cpu #(.MEM_DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .regs_debug  (regs_debug),
        .pc_debug    (pc_debug),
        .instr_debug (instr_debug)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int target);
        return {6'(op), 26'(target)};
    endfunction

    // ---------------- reference model ----------------
    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
        mdl_pc = '0;
        mdl_ir = '0;
    endtask

    // Executes one instruction architecturally; returns its clock count.
    function automatic int mdl_step();
        logic [31:0] ins, rsv, rtv, simm, zimm, npc, val, ea;
        logic [5:0]  op, fn;
        int          dst, cyc;
        ins  = mdl_mem[mdl_pc[9:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        rsv  = mdl_regs[ins[25:21]];
        rtv  = mdl_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0000, ins[15:0]};
        npc  = mdl_pc + 32'd4;
        dst  = 0;
        val  = '0;
        cyc  = 2;
        if (op == 6'h00) begin
            cyc = 4;
            dst = int'(ins[15:11]);
            case (fn)
                6'h00: val = rtv << ins[10:6];
                6'h02: val = rtv >> ins[10:6];
                6'h03: val = 32'($signed(rtv) >>> ins[10:6]);
                6'h04: val = rtv << rsv[4:0];
                6'h06: val = rtv >> rsv[4:0];
                6'h07: val = 32'($signed(rtv) >>> rsv[4:0]);
                6'h20, 6'h21: val = rsv + rtv;
                6'h22, 6'h23: val = rsv - rtv;
                6'h24: val = rsv & rtv;
                6'h25: val = rsv | rtv;
                6'h26: val = rsv ^ rtv;
                6'h27: val = ~(rsv | rtv);
                6'h2A: val = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                6'h2B: val = (rsv < rtv) ? 32'd1 : 32'd0;
                6'h08: begin cyc = 3; dst = 0; npc = rsv; end
                default: begin cyc = 2; dst = 0; end
            endcase
        end else begin
            case (op)
                6'h02: begin cyc = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
                6'h03: begin
                    cyc = 3; dst = 31; val = mdl_pc + 32'd4;
                    npc = {npc[31:28], ins[25:0], 2'b00};
                end
                6'h04: begin cyc = 3; if (rsv == rtv) npc = npc + (simm << 2); end
                6'h05: begin cyc = 3; if (rsv != rtv) npc = npc + (simm << 2); end
                6'h08, 6'h09: begin cyc = 4; dst = int'(ins[20:16]); val = rsv + simm; end
                6'h0A: begin cyc = 4; dst = int'(ins[20:16]); val = ($signed(rsv) < $signed(simm)) ? 32'd1 : 32'd0; end
                6'h0B: begin cyc = 4; dst = int'(ins[20:16]); val = (rsv < simm) ? 32'd1 : 32'd0; end
                6'h0C: begin cyc = 4; dst = int'(ins[20:16]); val = rsv & zimm; end
                6'h0D: begin cyc = 4; dst = int'(ins[20:16]); val = rsv | zimm; end
                6'h0E: begin cyc = 4; dst = int'(ins[20:16]); val = rsv ^ zimm; end
                6'h0F: begin cyc = 4; dst = int'(ins[20:16]); val = {ins[15:0], 16'h0000}; end
                6'h23: begin
                    cyc = 5; dst = int'(ins[20:16]); ea = rsv + simm; val = mdl_mem[ea[9:2]];
                end
                6'h2B: begin cyc = 4; ea = rsv + simm; mdl_mem[ea[9:2]] = rtv; end
                default: cyc = 2;
            endcase
        end
        if (dst != 0) mdl_regs[dst] = val;
        mdl_pc = npc;
        mdl_ir = ins;
        return cyc;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) begin
            dut.i_ram.mem[i] = prog[i];
            mdl_mem[i]       = prog[i];
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = '0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) if (regs_debug[i] !== mdl_regs[i]) idx = i;
        check32({tag, " pc"}, pc_debug, mdl_pc);
        check32({tag, " ir"}, instr_debug, mdl_ir);
        check32($sformatf("%s reg%0d", tag, idx), regs_debug[idx], mdl_regs[idx]);
    endtask

    task automatic check_regs_zero(input string tag);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) if (regs_debug[i] !== 32'd0) idx = i;
        check32($sformatf("%s reg%0d", tag, idx), regs_debug[idx], 32'd0);
        check32({tag, " pc"}, pc_debug, 32'd0);
        check32({tag, " ir"}, instr_debug, 32'd0);
    endtask

    task automatic check_mem(input string tag);
        int idx;
        idx = 0;
        for (int i = 255; i >= 0; i--) if (dut.i_ram.mem[i] !== mdl_mem[i]) idx = i;
        check32($sformatf("%s mem%0d", tag, idx), dut.i_ram.mem[idx], mdl_mem[idx]);
    endtask

    task automatic run_checked(input string tag, input int n);
        int cyc;
        for (int k = 0; k < n; k++) begin
            cyc = mdl_step();
            step(cyc);
            check_state($sformatf("%s i%0d", tag, k));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int          rfn [16] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h20, 'h21,
                                  'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
        int          k;
        k = int'($urandom_range(0, 15));
        if (k <= 5)       return enc_r(rfn[$urandom_range(0, 15)], $urandom_range(0, 31),
                                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        else if (k <= 9)  return enc_i($urandom_range(8, 15), $urandom_range(0, 31),
                                       $urandom_range(0, 31), $urandom);
        else if (k == 10) return enc_i('h23, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        else if (k == 11) return enc_i('h2B, $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
        else if (k == 12) return enc_i($urandom_range(4, 5), $urandom_range(0, 31),
                                       $urandom_range(0, 31), int'($urandom_range(0, 6)) - 3);
        else if (k == 13) return enc_j($urandom_range(2, 3), $urandom_range(0, 63));
        else if (k == 14) return enc_r('h08, $urandom_range(0, 31), 0, 0, 0);
        else              return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        clear_prog();
        prog[0]  = enc_i('h09, 0, 8, 10);
        prog[1]  = enc_i('h09, 0, 9, 20);
        prog[2]  = enc_r('h20, 8, 9, 20, 0);
        prog[3]  = enc_r('h21, 8, 9, 21, 0);
        prog[4]  = enc_r('h22, 8, 9, 22, 0);
        prog[5]  = enc_r('h23, 8, 9, 23, 0);
        prog[6]  = enc_i('h09, 0, 5, -1);
        prog[7]  = enc_i('h08, 9, 11, -4);
        prog[8]  = enc_i('h08, 8, 12, -20);
        prog[9]  = enc_r('h2A, 8, 0, 2, 0);
        prog[10] = enc_r('h2B, 8, 0, 3, 0);
        prog[11] = enc_r('h2A, 8, 9, 4, 0);
        prog[12] = enc_i('h09, 0, 6, 3);
        prog[13] = enc_r('h2B, 6, 5, 7, 0);
        prog[14] = enc_r('h00, 0, 8, 13, 3);
        prog[15] = enc_r('h02, 0, 6, 14, 1);
        prog[16] = enc_r('h03, 0, 6, 15, 1);
        prog[17] = enc_i('h0F, 0, 17, 'h8000);
        prog[18] = enc_r('h03, 0, 17, 24, 4);
        prog[19] = enc_i('h09, 0, 16, 3);
        prog[20] = enc_r('h04, 16, 8, 25, 0);
        prog[21] = enc_i('h09, 0, 18, 'h1234);
        prog[22] = enc_i('h2B, 0, 18, 'h40);
        prog[23] = enc_i('h23, 0, 19, 'h40);
        prog[24] = enc_i('h09, 0, 0, 5);
        prog[25] = enc_i('h04, 8, 8, 1);
        prog[26] = enc_i('h09, 0, 18, 'h7777);
        prog[27] = enc_j('h03, 29);
        prog[28] = enc_i('h09, 0, 18, 'h6666);
        prog[29] = enc_i('h05, 8, 8, 1);
        prog[30] = enc_i('h09, 0, 1, 'h99);
        prog[31] = enc_i('h09, 0, 26, 'h84);
        prog[32] = enc_r('h08, 26, 0, 0, 0);
        prog[33] = enc_j('h02, 33);
        load_prog();
        mdl_reset();
        #12;
        check_regs_zero("reset");
        reset = 1'b1;

        run_checked("dir", 36);
        check32("add",    regs_debug[20], 32'h0000001E);
        check32("addu",   regs_debug[21], 32'h0000001E);
        check32("sub",    regs_debug[22], 32'hFFFFFFF6);
        check32("subu",   regs_debug[23], 32'hFFFFFFF6);
        check32("addiu-1", regs_debug[5], 32'hFFFFFFFF);
        check32("addi-4", regs_debug[11], 32'h00000010);
        check32("addi-20", regs_debug[12], 32'hFFFFFFF6);
        check32("slt0",   regs_debug[2],  32'd0);
        check32("sltu0",  regs_debug[3],  32'd0);
        check32("slt1",   regs_debug[4],  32'd1);
        check32("sltu1",  regs_debug[7],  32'd1);
        check32("sll",    regs_debug[13], 32'h00000050);
        check32("srl",    regs_debug[14], 32'd1);
        check32("sra",    regs_debug[15], 32'd1);
        check32("sra_neg", regs_debug[24], 32'hF8000000);
        check32("sllv",   regs_debug[25], 32'h00000050);
        check32("lw",     regs_debug[19], 32'h00001234);
        check32("beq_skip", regs_debug[18], 32'h00001234);
        check32("zero",   regs_debug[0],  32'd0);
        check32("jal_ra", regs_debug[31], 32'h00000070);
        check32("after_bne", regs_debug[1], 32'h00000099);
        check32("j_loop", pc_debug,       32'h00000084);
        check32("sw_mem", dut.i_ram.mem[16], 32'h00001234);

        // Reset aborts a sw in flight and a lw in flight.
        reset = 1'b0;
        clear_prog();
        prog[0]  = enc_i('h09, 0, 8, 'h55);
        prog[1]  = enc_i('h2B, 0, 8, 'h100);
        prog[2]  = enc_i('h23, 0, 9, 'h100);
        prog[3]  = enc_j('h02, 3);
        prog[64] = 32'h0000ABCD;
        load_prog();
        mdl_reset();
        step(1);
        reset = 1'b1;
        run_checked("rst_a", 1);
        step(3);
        reset = 1'b0;
        #1;
        check_regs_zero("mid_sw");
        step(3);
        check32("sw_aborted", dut.i_ram.mem[64], 32'h0000ABCD);
        reset = 1'b1;
        mdl_reset();
        run_checked("rst_b", 2);
        check32("sw_done", dut.i_ram.mem[64], 32'h00000055);
        step(3);
        reset = 1'b0;
        #1;
        check_regs_zero("mid_lw");
        step(1);
        reset = 1'b1;
        mdl_reset();
        run_checked("rerun", 6);
        check32("rerun_lw", regs_debug[9], 32'h00000055);

        // Random programs against the interpreter.
        for (int r = 0; r < 4; r++) begin
            reset = 1'b0;
            clear_prog();
            for (int i = 0; i < 8; i++) prog[i] = enc_i('h09, 0, $urandom_range(1, 31), $urandom);
            for (int i = 8; i < 64; i++) prog[i] = rand_instr();
            load_prog();
            mdl_reset();
            step(1);
            check_regs_zero($sformatf("rnd%0d reset", r));
            reset = 1'b1;
            run_checked($sformatf("rnd%0d", r), 70);
            check_mem($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
